vx_ag_tcu_mx_scale: RTL and testbench
=====================================

# vx_ag_tcu_mx_scale

Multi-channel, pipelined shared-scale combiner for the AG tensor core unit. It generalises the single 8-bit `scale_a + scale_b` add to NUM_CH independent E8M0 block-scale lanes, with bias removal, saturation, NaN propagation and a group-max accumulate mode. It sits between the TCU dispatch stage and the tensor datapath, on a valid/ready stream in front of the scale-application logic.

## Interface
Parameters:
- NUM_CH, 4: independent scale lanes per beat.
- SCALE_W, 8: scale field width (E8M0 exponent).
- BIAS, 127: exponent bias removed once per product.
- TAG_W, 16: opaque tag (wid/PC/uuid slice), passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronised externally.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_mode  in  2  0 = PRODUCT, 1 = PASS_A, 2 = GROUP_MAX, 3 = reserved (treated as PRODUCT).
- in_last  in  1  final beat of a GROUP_MAX group; ignored in other modes.
- in_scale_a  in  NUM_CH*SCALE_W  lane-packed A scales.
- in_scale_b  in  NUM_CH*SCALE_W  lane-packed B scales.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_scale  out  NUM_CH*SCALE_W  combined E8M0 scales.
- out_nan  out  NUM_CH  lane result is NaN (0xFF).
- out_sat  out  NUM_CH  lane result was clamped (high or low).
- out_tag  out  TAG_W  tag of the producing beat (the `in_last` beat in GROUP_MAX).

## Operation
- A beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
- Per-lane arithmetic is done at SCALE_W+2 bits, signed: e = a + b − BIAS.
  - e > 254: clamp to 254 and set sat.
  - e < 0: clamp to 0 and set sat.
  - a == 0xFF or b == 0xFF: result 0xFF, nan = 1, sat = 0.
- PASS_A: result = a. The NaN rule applies to a only; sat is always 0.
- GROUP_MAX:
  - Each beat computes the PRODUCT result per lane and folds it into a per-lane running max register, reset value 0.
  - nan and sat are sticky (ORed) per lane across the group.
  - Non-last beats are consumed and produce no output.
  - The last beat emits max(running, current) with the accumulated flags, then clears all accumulators to 0 in the same cycle.
  - A single-beat group (in_last on the first beat) behaves as PRODUCT.
- A PRODUCT or PASS_A beat arriving mid-group is processed normally and leaves the accumulators untouched.
- Reset mid-group discards the partial group and clears the accumulators; no output is produced for it.

## Timing
- Pipeline stage S1 registers the raw sums, NaN detect and mode. Stage S2 does clamp/max and registers the outputs.
- Latency is 2 cycles from accepting a beat to out_valid, with no backpressure.
- Full throughput is 1 beat per cycle.
- Stalling uses standard bubble-collapsing valid/ready:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or advancing.
  - in_ready = !S1.valid || S1 advancing. in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Non-last GROUP_MAX beats leave S2 without setting out_valid. They never stall on out_ready.
- out_* data is stable while out_valid && !out_ready.
- Values while reset = 0:
  - in_ready = 0, out_valid = 0.
  - out_scale, out_nan, out_sat, out_tag = 0.
  - Both stage valids = 0; accumulators = 0.
- in_ready rises on the first clock after reset deasserts.

## Structure
- Shared package VX_ag_tcu_pkg gets:
  - the mode enum (AG_SCALE_PRODUCT / PASS_A / GROUP_MAX);
  - the E8M0 constants: NaN 0xFF, max finite 254, bias 127.
- Sub-module vx_ag_tcu_mx_scale_lane: one lane's combinational arithmetic (sum, clamp, NaN, max fold), instantiated NUM_CH times via generate.
- Pipeline registers, handshake and the group-accumulator registers stay in the top module.

## Test plan
1. PRODUCT, lane0 a=127, b=130 -> out 130, sat=0, nan=0, out_valid exactly 2 cycles after accept, tag echoed.
2. Saturation:
   - a=200, b=200 -> 254 with sat=1.
   - a=10, b=20 -> 0 with sat=1.
   - a=0xFF, b=5 -> 0xFF with nan=1, sat=0.
3. GROUP_MAX, 3 beats with lane0 products 120, 140, 130 (last) -> a single output of 140 carrying the third beat's tag; no output for beats 1–2.
4. Backpressure: hold out_ready=0 for 5 cycles with 4 back-to-back PRODUCT beats.
   - in_ready drops after 2 beats are accepted.
   - Output data stays stable while stalled.
   - All 4 results emerge in order once out_ready=1.
5. Reset mid-group: 2 non-last GROUP_MAX beats (lane0 = 200), pulse reset low, then a 1-beat group of product 50 -> output 50 and no stale 200; all outputs are 0 during reset.
6. Random stream across all modes against a reference model, NUM_CH=8, random out_ready -> no lost or duplicated results, and flags match.

Source files
------------

// File: rtl/vx_ag_tcu_mx_scale_pkg.sv
// -----------------------------------------------------------------------------
// VX_ag_tcu_pkg
// Shared definitions for the AG tensor core unit block-scale logic.
//   ag_scale_mode_e : operation selected per beat (PRODUCT / PASS_A / GROUP_MAX)
//   E8M0_*          : E8M0 exponent encodings (NaN, largest finite value, bias)
//   decode_mode     : maps the raw 2-bit request mode onto the enum; the
//                     reserved encoding falls back to PRODUCT
// -----------------------------------------------------------------------------
package VX_ag_tcu_pkg;

  typedef enum logic [1:0] {
    AG_SCALE_PRODUCT   = 2'd0,
    AG_SCALE_PASS_A    = 2'd1,
    AG_SCALE_GROUP_MAX = 2'd2
  } ag_scale_mode_e;

  localparam logic [7:0] E8M0_NAN        = 8'hFF;
  localparam logic [7:0] E8M0_MAX_FINITE = 8'd254;
  localparam int         E8M0_BIAS       = 127;

  function automatic ag_scale_mode_e decode_mode(input logic [1:0] i_raw);
    ag_scale_mode_e w_mode;
    case (i_raw)
      2'd1:    w_mode = AG_SCALE_PASS_A;
      2'd2:    w_mode = AG_SCALE_GROUP_MAX;
      default: w_mode = AG_SCALE_PRODUCT;
    endcase
    return w_mode;
  endfunction

endpackage

// File: rtl/vx_ag_tcu_mx_scale_lane.sv
// -----------------------------------------------------------------------------
// vx_ag_tcu_mx_scale_lane
// Combinational arithmetic for one E8M0 scale lane, split across the two
// pipeline stages of the parent block.
//   Front half (before S1): i_a, i_b, i_pass_a -> o_sum (signed, SCALE_W+2),
//                           o_nan (NaN input detected)
//   Back half  (before S2): i_sum, i_nan (registered front-half results),
//                           i_fold (GROUP_MAX beat), i_acc_max/i_acc_nan/
//                           i_acc_sat (running group state)
//                           -> o_res, o_res_nan, o_res_sat
// -----------------------------------------------------------------------------
module vx_ag_tcu_mx_scale_lane
  import VX_ag_tcu_pkg::*;
#(
  parameter int SCALE_W = 8,
  parameter int BIAS    = E8M0_BIAS
) (
  input  logic [SCALE_W-1:0]        i_a,
  input  logic [SCALE_W-1:0]        i_b,
  input  logic                      i_pass_a,
  output logic signed [SCALE_W+1:0] o_sum,
  output logic                      o_nan,
  input  logic signed [SCALE_W+1:0] i_sum,
  input  logic                      i_nan,
  input  logic                      i_fold,
  input  logic [SCALE_W-1:0]        i_acc_max,
  input  logic                      i_acc_nan,
  input  logic                      i_acc_sat,
  output logic [SCALE_W-1:0]        o_res,
  output logic                      o_res_nan,
  output logic                      o_res_sat
);

  localparam int SW = SCALE_W + 2;
  localparam logic [SCALE_W-1:0] NAN_L = {SCALE_W{1'b1}};
  localparam logic [SCALE_W-1:0] MAX_L = {{(SCALE_W-1){1'b1}}, 1'b0};

  logic signed [SW-1:0] w_a_ext;
  logic signed [SW-1:0] w_b_ext;
  logic signed [SW-1:0] w_bias;
  logic signed [SW-1:0] w_max_ext;
  logic [SCALE_W-1:0]   w_clamp;
  logic                 w_sat;

  // Two guard bits keep a + b - BIAS exact: the range is -BIAS .. 2*MAX+2-BIAS.
  assign w_a_ext   = $signed({2'b00, i_a});
  assign w_b_ext   = $signed({2'b00, i_b});
  assign w_bias    = SW'(BIAS);
  assign w_max_ext = $signed({2'b00, MAX_L});

  // In PASS_A the B operand is ignored entirely, including its NaN encoding.
  assign o_sum = i_pass_a ? w_a_ext : (w_a_ext + w_b_ext - w_bias);
  assign o_nan = (i_a == NAN_L) || (!i_pass_a && (i_b == NAN_L));

  // NaN wins over clamping and never reports saturation.
  always_comb begin
    w_clamp = i_sum[SCALE_W-1:0];
    w_sat   = 1'b0;
    if (i_nan) begin
      w_clamp = NAN_L;
    end else if (i_sum > w_max_ext) begin
      w_clamp = MAX_L;
      w_sat   = 1'b1;
    end else if (i_sum[SW-1]) begin
      w_clamp = '0;
      w_sat   = 1'b1;
    end
  end

  // Group fold: the accumulator starts at 0, so folding a fresh group is the
  // same as the plain product. NaN (all ones) naturally dominates the max.
  assign o_res     = (i_fold && (i_acc_max > w_clamp)) ? i_acc_max : w_clamp;
  assign o_res_nan = i_nan | (i_fold & i_acc_nan);
  assign o_res_sat = w_sat | (i_fold & i_acc_sat);

endmodule

// File: rtl/vx_ag_tcu_mx_scale.sv
// -----------------------------------------------------------------------------
// vx_ag_tcu_mx_scale
// Multi-lane pipelined E8M0 shared-scale combiner for the AG tensor core unit.
// Two register stages (S1: raw sums / NaN / mode, S2: clamped+folded result)
// behind a bubble-collapsing valid/ready stream.
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_mode, in_last, in_scale_a, in_scale_b, in_tag
//   out_valid/out_ready, out_scale, out_nan, out_sat, out_tag
// Lane g occupies bits [g*SCALE_W +: SCALE_W] of the packed scale buses.
// -----------------------------------------------------------------------------
module vx_ag_tcu_mx_scale
  import VX_ag_tcu_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int SCALE_W = 8,
  parameter int BIAS    = E8M0_BIAS,
  parameter int TAG_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_mode,
  input  logic                        in_last,
  input  logic [NUM_CH*SCALE_W-1:0]   in_scale_a,
  input  logic [NUM_CH*SCALE_W-1:0]   in_scale_b,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*SCALE_W-1:0]   out_scale,
  output logic [NUM_CH-1:0]           out_nan,
  output logic [NUM_CH-1:0]           out_sat,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int SW = SCALE_W + 2;

  ag_scale_mode_e w_in_mode;
  logic           w_in_pass_a;
  logic           w_in_fire;
  logic           w_s2_free;
  logic           w_s1_group_mid;
  logic           w_s1_fold;
  logic           w_s1_adv;

  logic [NUM_CH-1:0][SW-1:0]      w_sum;
  logic [NUM_CH-1:0]              w_nan;
  logic [NUM_CH-1:0][SCALE_W-1:0] w_res;
  logic [NUM_CH-1:0]              w_res_nan;
  logic [NUM_CH-1:0]              w_res_sat;

  logic                           r_run;
  logic                           r_s1_valid;
  ag_scale_mode_e                 r_s1_mode;
  logic                           r_s1_last;
  logic [TAG_W-1:0]               r_s1_tag;
  logic [NUM_CH-1:0][SW-1:0]      r_s1_sum;
  logic [NUM_CH-1:0]              r_s1_nan;

  logic                           r_out_valid;
  logic [NUM_CH-1:0][SCALE_W-1:0] r_out_scale;
  logic [NUM_CH-1:0]              r_out_nan;
  logic [NUM_CH-1:0]              r_out_sat;
  logic [TAG_W-1:0]               r_out_tag;

  logic [NUM_CH-1:0][SCALE_W-1:0] r_acc_max;
  logic [NUM_CH-1:0]              r_acc_nan;
  logic [NUM_CH-1:0]              r_acc_sat;

  assign w_in_mode   = decode_mode(in_mode);
  assign w_in_pass_a = (w_in_mode == AG_SCALE_PASS_A);

  // A non-last GROUP_MAX beat only touches the accumulators, so it may leave
  // S1 even while S2 is holding a result the consumer has not taken.
  assign w_s2_free      = !r_out_valid || out_ready;
  assign w_s1_fold      = (r_s1_mode == AG_SCALE_GROUP_MAX);
  assign w_s1_group_mid = w_s1_fold && !r_s1_last;
  assign w_s1_adv       = r_s1_valid && (w_s2_free || w_s1_group_mid);

  // r_run keeps in_ready low until the first clock after reset is released.
  assign in_ready  = r_run && (!r_s1_valid || w_s1_adv);
  assign w_in_fire = in_valid && in_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    vx_ag_tcu_mx_scale_lane #(
      .SCALE_W (SCALE_W),
      .BIAS    (BIAS)
    ) u_lane (
      .i_a       (in_scale_a[g*SCALE_W +: SCALE_W]),
      .i_b       (in_scale_b[g*SCALE_W +: SCALE_W]),
      .i_pass_a  (w_in_pass_a),
      .o_sum     (w_sum[g]),
      .o_nan     (w_nan[g]),
      .i_sum     (r_s1_sum[g]),
      .i_nan     (r_s1_nan[g]),
      .i_fold    (w_s1_fold),
      .i_acc_max (r_acc_max[g]),
      .i_acc_nan (r_acc_nan[g]),
      .i_acc_sat (r_acc_sat[g]),
      .o_res     (w_res[g]),
      .o_res_nan (w_res_nan[g]),
      .o_res_sat (w_res_sat[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // S1: capture raw per-lane sums, NaN detect and the decoded mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= AG_SCALE_PRODUCT;
      r_s1_last  <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_sum   <= '0;
      r_s1_nan   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_mode  <= w_in_mode;
      r_s1_last  <= in_last;
      r_s1_tag   <= in_tag;
      r_s1_sum   <= w_sum;
      r_s1_nan   <= w_nan;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 and group accumulators. Output data only changes when a result-producing
  // beat moves in, which requires S2 to be free, so held data stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_scale <= '0;
      r_out_nan   <= '0;
      r_out_sat   <= '0;
      r_out_tag   <= '0;
      r_acc_max   <= '0;
      r_acc_nan   <= '0;
      r_acc_sat   <= '0;
    end else if (w_s1_adv) begin
      if (w_s1_group_mid) begin
        r_acc_max <= w_res;
        r_acc_nan <= w_res_nan;
        r_acc_sat <= w_res_sat;
        if (w_s2_free) begin
          r_out_valid <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b1;
        r_out_scale <= w_res;
        r_out_nan   <= w_res_nan;
        r_out_sat   <= w_res_sat;
        r_out_tag   <= r_s1_tag;
        if (w_s1_fold) begin
          r_acc_max <= '0;
          r_acc_nan <= '0;
          r_acc_sat <= '0;
        end
      end
    end else if (w_s2_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_scale = r_out_scale;
  assign out_nan   = r_out_nan;
  assign out_sat   = r_out_sat;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_vx_ag_tcu_mx_scale.sv
// -----------------------------------------------------------------------------
// tb_vx_ag_tcu_mx_scale
// Directed vectors for vx_ag_tcu_mx_scale (NUM_CH = 8) followed by a short
// random stream checked against a behavioural reference model. Expected
// results are queued when a beat is accepted and popped by the output monitor.
// -----------------------------------------------------------------------------
module tb_vx_ag_tcu_mx_scale;
  import VX_ag_tcu_pkg::*;

  localparam int NCH = 8;

  typedef struct {
    logic [63:0] scale;
    logic [7:0]  nan;
    logic [7:0]  sat;
    logic [15:0] tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [1:0]  inMode;
  logic        inLast;
  logic [63:0] inA;
  logic [63:0] inB;
  logic [15:0] inTag;
  logic        outValid;
  logic        outReady;
  logic [63:0] outScale;
  logic [7:0]  outNan;
  logic [7:0]  outSat;
  logic [15:0] outTag;

  int   nTests = 0;
  int   nFail = 0;
  int   cyc = 0;
  int   acceptCyc = 0;
  int   lastOutCyc = 0;
  int   outCount = 0;
  bit   randReady = 0;
  exp_t expQ[$];

  logic [7:0]  accM[NCH];
  logic        accN[NCH];
  logic        accS[NCH];

  vx_ag_tcu_mx_scale #(
    .NUM_CH  (NCH),
    .SCALE_W (8),
    .BIAS    (127),
    .TAG_W   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_mode    (inMode),
    .in_last    (inLast),
    .in_scale_a (inA),
    .in_scale_b (inB),
    .in_tag     (inTag),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_scale  (outScale),
    .out_nan    (outNan),
    .out_sat    (outSat),
    .out_tag    (outTag)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Single point of comparison: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: samples on the falling edge and pops the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", {48'd0, outTag}, 64'hDEAD);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_scale", outScale, e.scale);
          checkOutput("out_nan", {56'd0, outNan}, {56'd0, e.nan});
          checkOutput("out_sat", {56'd0, outSat}, {56'd0, e.sat});
          checkOutput("out_tag", {48'd0, outTag}, {48'd0, e.tag});
        end
        lastOutCyc = cyc;
        outCount++;
      end
    end
  end

  // Random consumer backpressure for the random stream
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) outReady = ($urandom_range(0, 3) != 0);
    end
  end

  // Behavioural per-lane reference: {nan, sat, result}
  function automatic logic [9:0] refLane(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b);
    int e;
    if (mode == 2'd1) return (a == E8M0_NAN) ? {2'b10, E8M0_NAN} : {2'b00, a};
    if (a == E8M0_NAN || b == E8M0_NAN) return {2'b10, E8M0_NAN};
    e = int'(a) + int'(b) - E8M0_BIAS;
    if (e > 254) return {2'b01, E8M0_MAX_FINITE};
    if (e < 0) return {2'b01, 8'd0};
    return {2'b00, 8'(e)};
  endfunction

  function automatic logic [7:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 8'hFF;
      1: return 8'd0;
      2: return 8'd254;
      3: return 8'd127;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Present one beat, wait (bounded) for acceptance, queue its expectation.
  // Entered and left at posedge+1.
  task automatic driveBeat(input logic [1:0] mode, input logic last, input logic [63:0] av,
                           input logic [63:0] bv, input logic [15:0] tg, input bit expOut, input exp_t e);
    bit ok;
    ok = 0;
    inValid = 1'b1;
    inMode  = mode;
    inLast  = last;
    inA     = av;
    inB     = bv;
    inTag   = tg;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (inReady) begin
        ok = 1;
        acceptCyc = cyc;
        if (expOut) expQ.push_back(e);
      end
    end
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Directed beat: the same a/b on every lane, hand-computed expectation
  task automatic applyStimulus(input logic [1:0] mode, input logic last, input logic [7:0] a,
                               input logic [7:0] b, input logic [15:0] tg, input bit expOut,
                               input logic [7:0] eScale, input bit eNan, input bit eSat);
    exp_t e;
    e.scale = {NCH{eScale}};
    e.nan   = {NCH{eNan}};
    e.sat   = {NCH{eSat}};
    e.tag   = tg;
    driveBeat(mode, last, {NCH{a}}, {NCH{b}}, tg, expOut, e);
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 300 && expQ.size() != 0; t++) @(negedge clk);
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, {63'd0, inReady}, 64'd0);
    checkOutput({tag, "_out_valid"}, {63'd0, outValid}, 64'd0);
    checkOutput({tag, "_out_scale"}, outScale, 64'd0);
    checkOutput({tag, "_out_nan"}, {56'd0, outNan}, 64'd0);
    checkOutput({tag, "_out_sat"}, {56'd0, outSat}, 64'd0);
    checkOutput({tag, "_out_tag"}, {48'd0, outTag}, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    int          nAcc;
    int          cnt0;
    reset    = 1'b0;
    inValid  = 1'b0;
    inMode   = 2'd0;
    inLast   = 1'b0;
    inA      = '0;
    inB      = '0;
    inTag    = '0;
    outReady = 1'b1;
    for (int l = 0; l < NCH; l++) begin
      accM[l] = 8'd0;
      accN[l] = 1'b0;
      accS[l] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("rst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_release_ready_low", {63'd0, inReady}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_first_clk_ready", {63'd0, inReady}, 64'd1);

    // PRODUCT basic, latency and tag echo
    applyStimulus(2'd0, 1'b0, 8'd127, 8'd130, 16'hA001, 1, 8'd130, 0, 0);
    waitDrain();
    checkOutput("t1_latency", 64'(lastOutCyc - acceptCyc), 64'd2);

    // Saturation, NaN and boundaries
    applyStimulus(2'd0, 1'b0, 8'd200, 8'd200, 16'hB001, 1, 8'd254, 0, 1);
    applyStimulus(2'd0, 1'b0, 8'd10,  8'd20,  16'hB002, 1, 8'd0,   0, 1);
    applyStimulus(2'd0, 1'b0, 8'hFF,  8'd5,   16'hB003, 1, 8'hFF,  1, 0);
    applyStimulus(2'd0, 1'b0, 8'd127, 8'd254, 16'hB004, 1, 8'd254, 0, 0);
    applyStimulus(2'd0, 1'b0, 8'd128, 8'd254, 16'hB005, 1, 8'd254, 0, 1);
    applyStimulus(2'd0, 1'b0, 8'd0,   8'd127, 16'hB006, 1, 8'd0,   0, 0);
    applyStimulus(2'd0, 1'b0, 8'd0,   8'd126, 16'hB007, 1, 8'd0,   0, 1);
    applyStimulus(2'd3, 1'b0, 8'd100, 8'd100, 16'hB008, 1, 8'd73,  0, 0);
    applyStimulus(2'd1, 1'b0, 8'd77,  8'hFF,  16'hB009, 1, 8'd77,  0, 0);
    applyStimulus(2'd1, 1'b0, 8'hFF,  8'd3,   16'hB00A, 1, 8'hFF,  1, 0);
    waitDrain();

    // GROUP_MAX: 120, 140, 130(last) -> 140 with third tag, nothing before
    cnt0 = outCount;
    applyStimulus(2'd2, 1'b0, 8'd127, 8'd120, 16'hC001, 0, 8'd0, 0, 0);
    applyStimulus(2'd2, 1'b0, 8'd127, 8'd140, 16'hC002, 0, 8'd0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("grp_no_out", 64'(outCount), 64'(cnt0));
    applyStimulus(2'd2, 1'b1, 8'd127, 8'd130, 16'hC003, 1, 8'd140, 0, 0);
    waitDrain();

    // Sticky NaN across a group, sticky sat across a group
    applyStimulus(2'd2, 1'b0, 8'hFF,  8'd1,   16'hC101, 0, 8'd0,   0, 0);
    applyStimulus(2'd2, 1'b1, 8'd127, 8'd130, 16'hC102, 1, 8'hFF,  1, 0);
    applyStimulus(2'd2, 1'b0, 8'd10,  8'd20,  16'hC103, 0, 8'd0,   0, 0);
    applyStimulus(2'd2, 1'b1, 8'd127, 8'd100, 16'hC104, 1, 8'd100, 0, 1);
    // PRODUCT mid-group leaves the accumulators alone
    applyStimulus(2'd2, 1'b0, 8'd127, 8'd150, 16'hC105, 0, 8'd0,   0, 0);
    applyStimulus(2'd0, 1'b0, 8'd127, 8'd90,  16'hC106, 1, 8'd90,  0, 0);
    applyStimulus(2'd2, 1'b1, 8'd127, 8'd100, 16'hC107, 1, 8'd150, 0, 0);
    waitDrain();

    // Backpressure: out_ready low for 5 cycles with 4 back-to-back beats
    outReady = 1'b0;
    held = '0;
    nAcc = 0;
    fork
      begin
        applyStimulus(2'd0, 1'b0, 8'd127, 8'd10, 16'hD001, 1, 8'd10, 0, 0);
        applyStimulus(2'd0, 1'b0, 8'd127, 8'd20, 16'hD002, 1, 8'd20, 0, 0);
        applyStimulus(2'd0, 1'b0, 8'd127, 8'd30, 16'hD003, 1, 8'd30, 0, 0);
        applyStimulus(2'd0, 1'b0, 8'd127, 8'd40, 16'hD004, 1, 8'd40, 0, 0);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (inValid && inReady) nAcc++;
          if (c == 2) begin
            held = outScale;
            checkOutput("bp_valid_held", {63'd0, outValid}, 64'd1);
            checkOutput("bp_first_data", outScale, {NCH{8'd10}});
          end
          if (c == 4) begin
            checkOutput("bp_data_stable", outScale, held);
            checkOutput("bp_in_ready_low", {63'd0, inReady}, 64'd0);
          end
        end
        checkOutput("bp_accepted", 64'(nAcc), 64'd2);
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    waitDrain();

    // Reset mid-group discards the partial group
    applyStimulus(2'd2, 1'b0, 8'd127, 8'd200, 16'hE001, 0, 8'd0, 0, 0);
    applyStimulus(2'd2, 1'b0, 8'd127, 8'd200, 16'hE002, 0, 8'd0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_back", {63'd0, inReady}, 64'd1);
    applyStimulus(2'd2, 1'b1, 8'd127, 8'd50, 16'hE003, 1, 8'd50, 0, 0);
    waitDrain();

    // Random stream against the reference model with random out_ready
    randReady = 1;
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  m;
      logic        lastB;
      logic [15:0] tg;
      logic [63:0] av;
      logic [63:0] bv;
      logic [9:0]  r;
      logic [7:0]  mx;
      exp_t        e;
      bit          emits;
      m     = 2'($urandom_range(0, 3));
      lastB = ($urandom_range(0, 2) == 0);
      tg    = 16'($urandom);
      e.tag = tg;
      for (int l = 0; l < NCH; l++) begin
        av[l*8 +: 8] = pickVal();
        bv[l*8 +: 8] = pickVal();
        r = refLane(m, av[l*8 +: 8], bv[l*8 +: 8]);
        if (m == 2'd2) begin
          mx = (accM[l] > r[7:0]) ? accM[l] : r[7:0];
          e.scale[l*8 +: 8] = mx;
          e.nan[l] = accN[l] | r[9];
          e.sat[l] = accS[l] | r[8];
          if (lastB) begin
            accM[l] = 8'd0;
            accN[l] = 1'b0;
            accS[l] = 1'b0;
          end else begin
            accM[l] = mx;
            accN[l] = e.nan[l];
            accS[l] = e.sat[l];
          end
        end else begin
          e.scale[l*8 +: 8] = r[7:0];
          e.nan[l] = r[9];
          e.sat[l] = r[8];
        end
      end
      emits = (m != 2'd2) || lastB;
      driveBeat(m, lastB, av, bv, tg, emits, e);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    randReady = 0;
    @(posedge clk);
    #1;
    outReady = 1'b1;
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
